// File: rtl/search_candidate_filter.sv
// Candidate filter: 3-stage hash pipeline, masked compare against a runtime target,
// first-word-fall-through match FIFO, saturating match counter and completion flag.
module search_candidate_filter #(
  parameter int                   SEQ_WIDTH   = 8,
  parameter logic [SEQ_WIDTH-1:0] HASH_KEY    = 8'h5A,
  parameter int                   FIFO_DEPTH  = 4,
  parameter int                   COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEQ_WIDTH-1:0]   i_seq,
  input  logic                   i_valid,
  input  logic                   i_done,
  input  logic [SEQ_WIDTH-1:0]   i_target,
  input  logic [SEQ_WIDTH-1:0]   i_mask,
  output logic [SEQ_WIDTH-1:0]   o_match_seq,
  output logic                   o_match_valid,
  input  logic                   i_match_ready,
  output logic [COUNT_WIDTH-1:0] o_match_count,
  output logic                   o_overflow,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = FIFO_DEPTH[AW:0];

  typedef logic [SEQ_WIDTH-1:0]   word_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  function automatic word_t mix_s1(input word_t x);
    return x ^ {x[SEQ_WIDTH-2:0], x[SEQ_WIDTH-1]};
  endfunction

  function automatic word_t mix_s2(input word_t x);
    return x + HASH_KEY;
  endfunction

  function automatic word_t mix_s3(input word_t x);
    return x ^ (x >> 2);
  endfunction

  function automatic count_t sat_inc(input count_t c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic  vld_p0, vld_p1, vld_p2;
  word_t hash_p0, hash_p1, hash_p2;
  word_t seq_p0, seq_p1, seq_p2;

  logic          done_seen;
  logic [AW:0]   occ;
  logic [AW-1:0] wr_ptr, rd_ptr;
  word_t         mem [FIFO_DEPTH];

  logic match, full, push, pop, drop;

  // Stage valids: control, reset flushes anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= i_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage p0: rotate-xor, p1: add key, p2: shift-xor; candidate rides alongside
  always_ff @(posedge clk) begin
    hash_p0 <= mix_s1(i_seq);
    seq_p0  <= i_seq;
    hash_p1 <= mix_s2(hash_p0);
    seq_p1  <= seq_p0;
    hash_p2 <= mix_s3(hash_p1);
    seq_p2  <= seq_p1;
  end

  // Match decision and FIFO handshakes off stage p2
  always_comb begin
    match = vld_p2 & ((hash_p2 & i_mask) == (i_target & i_mask));
    full  = (occ == FULL_OCC);
    pop   = (occ != '0) & i_match_ready;
    push  = match & (~full | pop);
    drop  = match & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_match_count <= '0;
      o_overflow    <= 1'b0;
      done_seen     <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (match) o_match_count <= sat_inc(o_match_count);
      if (drop)  o_overflow    <= 1'b1;
      if (i_done) done_seen <= 1'b1;
      // Pipeline is empty after this edge when nothing enters and p0/p1 drain out
      if (done_seen & ~i_valid & ~vld_p0 & ~vld_p1) o_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= seq_p2;
  end

  assign o_match_seq   = mem[rd_ptr];
  assign o_match_valid = (occ != '0);
  assign o_busy        = vld_p0 | vld_p1 | vld_p2;

endmodule

// File: tb/tb_search_candidate_filter.sv
// Bench for search_candidate_filter: directed scenarios plus random traffic, all
// compared each cycle against a queue-based transaction model.
module tb_search_candidate_filter;

  logic        clk;
  logic        rst;
  logic [7:0]  i_seq;
  logic        i_valid;
  logic        i_done;
  logic [7:0]  i_target;
  logic [7:0]  i_mask;
  logic        i_match_ready;

  logic [7:0]  o_match_seq;
  logic        o_match_valid;
  logic [15:0] o_match_count;
  logic        o_overflow;
  logic        o_busy;
  logic        o_done;

  logic [7:0]  s_match_seq;
  logic        s_match_valid;
  logic [3:0]  s_match_count;
  logic        s_overflow;
  logic        s_busy;
  logic        s_done;

  int checks;
  int failures;

  search_candidate_filter #(
    .SEQ_WIDTH(8), .HASH_KEY(8'h5A), .FIFO_DEPTH(4), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .i_seq(i_seq), .i_valid(i_valid), .i_done(i_done),
    .i_target(i_target), .i_mask(i_mask), .o_match_seq(o_match_seq),
    .o_match_valid(o_match_valid), .i_match_ready(i_match_ready),
    .o_match_count(o_match_count), .o_overflow(o_overflow), .o_busy(o_busy),
    .o_done(o_done)
  );

  search_candidate_filter #(
    .SEQ_WIDTH(8), .HASH_KEY(8'h5A), .FIFO_DEPTH(4), .COUNT_WIDTH(4)
  ) dut_sat (
    .clk(clk), .rst(rst), .i_seq(i_seq), .i_valid(i_valid), .i_done(i_done),
    .i_target(i_target), .i_mask(i_mask), .o_match_seq(s_match_seq),
    .o_match_valid(s_match_valid), .i_match_ready(i_match_ready),
    .o_match_count(s_match_count), .o_overflow(s_overflow), .o_busy(s_busy),
    .o_done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] s;
  } ent_t;

  // Model: candidates sampled 3 edges ago resolve now; FIFO is a plain queue
  ent_t       m_pipe[$];
  logic [7:0] m_fifo[$];
  int         m_count;
  bit         m_ovf;
  bit         m_done_seen;
  bit         m_done;

  logic [7:0] pop_vals[$];

  function automatic logic [7:0] ref_hash(input logic [7:0] x);
    logic [7:0] a, b, r;
    a = x ^ {x[6:0], x[7]};
    b = a + 8'h5A;
    r = b ^ (b >> 2);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < 3; i++) m_pipe.push_back('{v: 1'b0, s: 8'h00});
    m_fifo.delete();
    m_count     = 0;
    m_ovf       = 0;
    m_done_seen = 0;
    m_done      = 0;
  endtask

  task automatic model_edge();
    ent_t e;
    int   occ0;
    bit   popped;
    bit   empty;
    if (rst) begin
      model_reset();
      return;
    end
    e      = m_pipe.pop_front();
    occ0   = m_fifo.size();
    popped = (occ0 > 0) && i_match_ready;
    if (popped) void'(m_fifo.pop_front());
    if (e.v && ((ref_hash(e.s) & i_mask) == (i_target & i_mask))) begin
      m_count++;
      if (occ0 < 4 || popped) m_fifo.push_back(e.s);
      else m_ovf = 1;
    end
    m_pipe.push_back('{v: i_valid, s: i_seq});
    empty = 1;
    foreach (m_pipe[k]) if (m_pipe[k].v) empty = 0;
    if (m_done_seen && empty) m_done = 1;
    if (i_done) m_done_seen = 1;
  endtask

  task automatic compare_all();
    chk("match_valid", o_match_valid, (m_fifo.size() > 0));
    if (m_fifo.size() > 0) chk("match_seq", o_match_seq, m_fifo[0]);
    chk("match_count", o_match_count, (m_count > 65535) ? 65535 : m_count);
    chk("overflow", o_overflow, m_ovf);
    chk("busy", o_busy, (m_pipe[0].v | m_pipe[1].v | m_pipe[2].v));
    chk("done", o_done, m_done);
    chk("sat_count", s_match_count, (m_count > 15) ? 15 : m_count);
  endtask

  task automatic step(input logic v, input logic [7:0] s, input logic d,
                      input logic rdy, input logic r = 1'b0);
    logic       will_pop;
    logic [7:0] head;
    rst = r; i_valid = v; i_seq = s; i_done = d; i_match_ready = rdy;
    will_pop = o_match_valid & rdy & ~r;
    head     = o_match_seq;
    @(posedge clk);
    model_edge();
    if (will_pop) pop_vals.push_back(head);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; i_valid = 1'b0; i_seq = '0; i_done = 1'b0;
    i_target = '0; i_mask = '0; i_match_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_match_valid", o_match_valid, 0);
    chk("rst_count", o_match_count, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);

    // Single match: only 0x00 hashes to 0x4C among 0x00..0x3F
    i_mask = 8'hFF; i_target = 8'h4C;
    do_reset();
    pop_vals.delete();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, i[7:0], 1'b0, 1'b1);
      if (i == 2) chk("sm_early_valid", o_match_valid, 0);
      if (i == 3) begin
        chk("sm_lat_valid", o_match_valid, 1);
        chk("sm_lat_seq", o_match_seq, 8'h00);
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("sm_pops", pop_vals.size(), 1);
    if (pop_vals.size() > 0) chk("sm_pop_val", pop_vals[0], 8'h00);
    chk("sm_count", o_match_count, 1);
    chk("sm_overflow", o_overflow, 0);

    // Overflow: everything matches, nothing popped
    i_mask = 8'h00;
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, i[7:0], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ov_count", o_match_count, 64);
    chk("ov_overflow", o_overflow, 1);
    chk("ov_sat_count", s_match_count, 15);
    pop_vals.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ov_drain_pops", pop_vals.size(), 4);
    foreach (pop_vals[i]) chk("ov_drain_val", pop_vals[i], i);
    chk("ov_drain_empty", o_match_valid, 0);

    // Push and pop on a full FIFO: ready rises exactly when the 5th match arrives
    do_reset();
    pop_vals.delete();
    for (int i = 0; i < 24; i++) step(1'b1, i[7:0], 1'b0, (i >= 7));
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pp_overflow", o_overflow, 0);
    chk("pp_pops", pop_vals.size(), 24);
    foreach (pop_vals[i]) chk("pp_val", pop_vals[i], i);

    // Done timing: last valid and done on the same edge
    i_mask = 8'hFF; i_target = 8'h00;
    do_reset();
    step(1'b1, 8'h05, 1'b0, 1'b1);
    step(1'b1, 8'h06, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dn_k1_done", o_done, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dn_k2_done", o_done, 0);
    chk("dn_k2_busy", o_busy, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dn_k3_done", o_done, 1);
    chk("dn_k3_busy", o_busy, 0);
    step(1'b1, 8'h07, 1'b0, 1'b1);
    chk("dn_hold_done", o_done, 1);
    chk("dn_hold_busy", o_busy, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dn_hold2_done", o_done, 1);

    // Reset mid-run: 2 in FIFO, 3 in flight
    i_mask = 8'h00;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, i[7:0] + 8'h10, 1'b0, 1'b0);
    chk("mr_pre_valid", o_match_valid, 1);
    chk("mr_pre_busy", o_busy, 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("mr_valid", o_match_valid, 0);
    chk("mr_count", o_match_count, 0);
    chk("mr_busy", o_busy, 0);
    pop_vals.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("mr_no_ghost", pop_vals.size(), 0);
    chk("mr_count_after", o_match_count, 0);

    // Saturation of the narrow counter
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, i[7:0], 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("sat_narrow", s_match_count, 15);
    chk("sat_wide", o_match_count, 20);

    // Random traffic against the model
    for (int r = 0; r < 4; r++) begin
      i_mask   = 8'((1 << $urandom_range(0, 7)) | (1 << $urandom_range(0, 7)));
      i_target = 8'($urandom);
      do_reset();
      for (int j = 0; j < 150; j++)
        step(($urandom_range(0, 3) != 0), 8'($urandom), (j == 140),
             ($urandom_range(0, 2) != 0));
      for (int j = 0; j < 5; j++) step(1'b0, 8'h00, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
